// File: rtl/cp0_pkg.sv
// cp0_pkg: shared definitions for the CP0 interrupt/exception block.
//   - CP0 register addresses encoded as {rd[4:0], sel[2:0]}
//   - bit positions inside Status and Cause
//   - reset images for Status, Cause and EPC
//   - the ExcCode enumeration
package cp0_pkg;

  // Register addresses {rd, sel}
  localparam logic [7:0] CP0_ADDR_COUNT   = {5'd9,  3'd0};
  localparam logic [7:0] CP0_ADDR_COMPARE = {5'd11, 3'd0};
  localparam logic [7:0] CP0_ADDR_STATUS  = {5'd12, 3'd0};
  localparam logic [7:0] CP0_ADDR_CAUSE   = {5'd13, 3'd0};
  localparam logic [7:0] CP0_ADDR_EPC     = {5'd14, 3'd0};

  // Status bit positions
  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_IM_HI = 15;
  localparam int STATUS_BEV   = 22;

  // Cause bit positions
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_BD     = 31;

  // Reset images
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] CAUSE_RESET  = 32'h0000_0000;
  localparam logic [31:0] EPC_RESET    = 32'h0000_0000;

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0a,
    EXC_OV   = 5'h0c
  } exc_code_e;

endpackage

// File: rtl/cp0_count_timer.sv
// cp0_count_timer: Count/Compare timer.
//   clk, rst     : clock and synchronous active-high reset
//   count_we     : load Count from wdata (also restarts the divider)
//   compare_we   : load Compare from wdata (also clears ti)
//   wdata        : write data for either register
//   count        : current Count
//   compare      : current Compare
//   ti           : sticky timer interrupt flag
module cp0_count_timer
  import cp0_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  // A 1-bit phase counter is kept even for COUNT_DIV == 1; it just stays at 0.
  localparam int PHASE_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PHASE_W-1:0] phase_reg;
  logic [31:0]        count_reg;
  logic [31:0]        compare_reg;
  logic               ti_reg;
  logic               tick;
  logic               match;

  assign tick  = (phase_reg == PHASE_W'(COUNT_DIV - 1));
  // Match uses the registered values, so ti rises one edge after equality.
  assign match = (count_reg == compare_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg   <= '0;
      count_reg   <= '0;
      compare_reg <= '0;
      ti_reg      <= 1'b0;
    end else begin
      // A software load wins over a same-cycle increment.
      if (count_we) begin
        count_reg <= wdata;
        phase_reg <= '0;
      end else if (tick) begin
        count_reg <= count_reg + 32'd1;
        phase_reg <= '0;
      end else begin
        phase_reg <= phase_reg + PHASE_W'(1);
      end

      // Rewriting Compare acknowledges the timer; the clear wins over a match.
      if (compare_we) begin
        compare_reg <= wdata;
        ti_reg      <= 1'b0;
      end else if (match) begin
        ti_reg <= 1'b1;
      end
    end
  end

  assign count   = count_reg;
  assign compare = compare_reg;
  assign ti      = ti_reg;

endmodule

// File: rtl/cp0_intr_ctrl.sv
// cp0_intr_ctrl: CP0 Status/Cause/EPC/Count/Compare register block.
//   clk, rst               : clock and synchronous active-high reset
//   mtc0_we/cp0_waddr/mtc0_data : MTC0 write port
//   cp0_raddr/cp0_rdata    : MFC0 read port (combinational, old value on RAW)
//   exception/ex_code/ex_bd/ex_pc : exception commit event
//   eret_flush             : ERET commit event
//   hw_int                 : asynchronous level interrupt sources
//   cp0_status/cp0_cause/cp0_epc : current register images
//   timer_int              : Cause.TI
//   int_req                : enabled interrupt pending
module cp0_intr_ctrl
  import cp0_pkg::*;
#(
  parameter int HW_INT_NUM  = 6,
  parameter int COUNT_DIV   = 2,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mtc0_we,
  input  logic [ADDR_W-1:0]     cp0_waddr,
  input  logic [31:0]           mtc0_data,
  input  logic [ADDR_W-1:0]     cp0_raddr,
  output logic [31:0]           cp0_rdata,
  input  logic                  exception,
  input  logic [4:0]            ex_code,
  input  logic                  ex_bd,
  input  logic [31:0]           ex_pc,
  input  logic                  eret_flush,
  input  logic [HW_INT_NUM-1:0] hw_int,
  output logic [31:0]           cp0_status,
  output logic [31:0]           cp0_cause,
  output logic [31:0]           cp0_epc,
  output logic                  timer_int,
  output logic                  int_req
);

  // Write decode
  logic we_count, we_compare, we_status, we_cause, we_epc;

  assign we_count   = mtc0_we && (cp0_waddr == ADDR_W'(CP0_ADDR_COUNT));
  assign we_compare = mtc0_we && (cp0_waddr == ADDR_W'(CP0_ADDR_COMPARE));
  assign we_status  = mtc0_we && (cp0_waddr == ADDR_W'(CP0_ADDR_STATUS));
  assign we_cause   = mtc0_we && (cp0_waddr == ADDR_W'(CP0_ADDR_CAUSE));
  assign we_epc     = mtc0_we && (cp0_waddr == ADDR_W'(CP0_ADDR_EPC));

  // Count / Compare / TI
  logic [31:0] count_val;
  logic [31:0] compare_val;
  logic        ti;

  cp0_count_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_count_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (we_count),
    .compare_we (we_compare),
    .wdata      (mtc0_data),
    .count      (count_val),
    .compare    (compare_val),
    .ti         (ti)
  );

  // Hardware interrupt synchronisers: one flop chain per line.
  logic [HW_INT_NUM-1:0] hw_sync;

  genvar gi;
  generate
    for (gi = 0; gi < HW_INT_NUM; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;
      if (SYNC_STAGES == 1) begin : g_one
        always_ff @(posedge clk) begin
          if (rst) chain_reg <= '0;
          else     chain_reg <= hw_int[gi];
        end
      end else begin : g_many
        always_ff @(posedge clk) begin
          if (rst) chain_reg <= '0;
          else     chain_reg <= {chain_reg[SYNC_STAGES-2:0], hw_int[gi]};
        end
      end
      assign hw_sync[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  // Map synced lines onto IP[7:2]; lines that do not exist read 0.
  logic [5:0] ip_hw;

  generate
    for (gi = 0; gi < 6; gi++) begin : g_ip
      if (gi < HW_INT_NUM) begin : g_present
        assign ip_hw[gi] = hw_sync[gi];
      end else begin : g_absent
        assign ip_hw[gi] = 1'b0;
      end
    end
  endgenerate

  // Status / Cause / EPC state
  logic [7:0]  status_im_reg;
  logic        status_exl_reg;
  logic        status_ie_reg;
  logic        cause_bd_reg;
  logic [4:0]  cause_exc_reg;
  logic [1:0]  cause_ip_sw_reg;
  logic [31:0] epc_reg;
  logic [31:0] epc_next;
  logic        epc_capture;

  // Only the first exception of a nest records EPC/BD.
  assign epc_capture = exception && !status_exl_reg;
  // A delay-slot fault returns to the branch, one word earlier.
  assign epc_next    = ex_bd ? (ex_pc - 32'd4) : ex_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      status_im_reg   <= STATUS_RESET[STATUS_IM_HI:STATUS_IM_LO];
      status_exl_reg  <= STATUS_RESET[STATUS_EXL];
      status_ie_reg   <= STATUS_RESET[STATUS_IE];
      cause_bd_reg    <= CAUSE_RESET[CAUSE_BD];
      cause_exc_reg   <= CAUSE_RESET[CAUSE_EXC_HI:CAUSE_EXC_LO];
      cause_ip_sw_reg <= CAUSE_RESET[CAUSE_IP_LO+1:CAUSE_IP_LO];
      epc_reg         <= EPC_RESET;
    end else begin
      // EXL ownership: exception, then ERET, then software.
      if (exception) begin
        status_exl_reg <= 1'b1;
        cause_exc_reg  <= ex_code;
        if (epc_capture) begin
          cause_bd_reg <= ex_bd;
        end
      end else if (eret_flush) begin
        status_exl_reg <= 1'b0;
      end else if (we_status) begin
        status_exl_reg <= mtc0_data[STATUS_EXL];
      end

      // IM/IE have no competing hardware writer.
      if (we_status) begin
        status_im_reg <= mtc0_data[STATUS_IM_HI:STATUS_IM_LO];
        status_ie_reg <= mtc0_data[STATUS_IE];
      end

      if (we_cause) begin
        cause_ip_sw_reg <= mtc0_data[CAUSE_IP_LO+1:CAUSE_IP_LO];
      end

      if (epc_capture) begin
        epc_reg <= epc_next;
      end else if (we_epc) begin
        epc_reg <= mtc0_data;
      end
    end
  end

  // Register images
  logic [7:0]  cause_ip;
  logic [31:0] status_word;
  logic [31:0] cause_word;

  // IP[7] is shared between hw line 5 and the timer.
  assign cause_ip = {ip_hw[5] | ti, ip_hw[4:0], cause_ip_sw_reg};

  always_comb begin
    status_word                            = '0;
    status_word[STATUS_BEV]                = 1'b1;
    status_word[STATUS_IM_HI:STATUS_IM_LO] = status_im_reg;
    status_word[STATUS_EXL]                = status_exl_reg;
    status_word[STATUS_IE]                 = status_ie_reg;
  end

  always_comb begin
    cause_word                            = '0;
    cause_word[CAUSE_BD]                  = cause_bd_reg;
    cause_word[CAUSE_TI]                  = ti;
    cause_word[CAUSE_IP_HI:CAUSE_IP_LO]   = cause_ip;
    cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc_reg;
  end

  // MFC0 read mux: pure function of registered state, so a same-cycle
  // write is not visible until the following cycle.
  always_comb begin
    cp0_rdata = '0;
    if (cp0_raddr == ADDR_W'(CP0_ADDR_COUNT))        cp0_rdata = count_val;
    else if (cp0_raddr == ADDR_W'(CP0_ADDR_COMPARE)) cp0_rdata = compare_val;
    else if (cp0_raddr == ADDR_W'(CP0_ADDR_STATUS))  cp0_rdata = status_word;
    else if (cp0_raddr == ADDR_W'(CP0_ADDR_CAUSE))   cp0_rdata = cause_word;
    else if (cp0_raddr == ADDR_W'(CP0_ADDR_EPC))     cp0_rdata = epc_reg;
  end

  assign cp0_status = status_word;
  assign cp0_cause  = cause_word;
  assign cp0_epc    = epc_reg;
  assign timer_int  = ti;
  assign int_req    = status_ie_reg && !status_exl_reg && |(status_im_reg & cause_ip);

endmodule

// File: tb/tb_cp0_intr_ctrl.sv
// tb_cp0_intr_ctrl: directed scenarios followed by randomized traffic, all
// checked against a cycle-level behavioural model of the CP0 register block.
module tb_cp0_intr_ctrl;

  localparam int HW_N  = 6;
  localparam int DIV   = 2;
  localparam int SYNC  = 2;
  localparam int AW    = 8;

  localparam logic [7:0] A_COUNT   = {5'd9,  3'd0};
  localparam logic [7:0] A_COMPARE = {5'd11, 3'd0};
  localparam logic [7:0] A_STATUS  = {5'd12, 3'd0};
  localparam logic [7:0] A_CAUSE   = {5'd13, 3'd0};
  localparam logic [7:0] A_EPC     = {5'd14, 3'd0};

  logic            clk = 1'b0;
  logic            rst;
  logic            mtc0_we;
  logic [AW-1:0]   cp0_waddr;
  logic [31:0]     mtc0_data;
  logic [AW-1:0]   cp0_raddr;
  logic [31:0]     cp0_rdata;
  logic            exception;
  logic [4:0]      ex_code;
  logic            ex_bd;
  logic [31:0]     ex_pc;
  logic            eret_flush;
  logic [HW_N-1:0] hw_int;
  logic [31:0]     cp0_status;
  logic [31:0]     cp0_cause;
  logic [31:0]     cp0_epc;
  logic            timer_int;
  logic            int_req;

  always #5 clk = ~clk;

  cp0_intr_ctrl #(
    .HW_INT_NUM  (HW_N),
    .COUNT_DIV   (DIV),
    .SYNC_STAGES (SYNC),
    .ADDR_W      (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mtc0_we    (mtc0_we),
    .cp0_waddr  (cp0_waddr),
    .mtc0_data  (mtc0_data),
    .cp0_raddr  (cp0_raddr),
    .cp0_rdata  (cp0_rdata),
    .exception  (exception),
    .ex_code    (ex_code),
    .ex_bd      (ex_bd),
    .ex_pc      (ex_pc),
    .eret_flush (eret_flush),
    .hw_int     (hw_int),
    .cp0_status (cp0_status),
    .cp0_cause  (cp0_cause),
    .cp0_epc    (cp0_epc),
    .timer_int  (timer_int),
    .int_req    (int_req)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]      m_im;
  logic            m_ie, m_exl, m_bd, m_ti;
  logic [4:0]      m_exc;
  logic [1:0]      m_ipsw;
  logic [31:0]     m_epc, m_compare;
  logic [31:0]     m_cnt_base;     // value last loaded into Count
  int unsigned     m_cnt_cycles;   // edges since that load
  logic [HW_N-1:0] m_hist[$];      // hw_int samples, most recent last

  function automatic logic [31:0] m_count();
    return m_cnt_base + 32'(m_cnt_cycles / DIV);
  endfunction

  function automatic logic [7:0] m_ip();
    logic [5:0] hw6;
    hw6 = '0;
    if (m_hist.size() == SYNC) hw6 = 6'(m_hist[0]);
    return {hw6[5] | m_ti, hw6[4:0], m_ipsw};
  endfunction

  function automatic logic [31:0] m_status();
    return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
  endfunction

  function automatic logic [31:0] m_cause();
    return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_exc) << 2);
  endfunction

  function automatic logic m_int_req();
    return m_ie && !m_exl && ((m_im & m_ip()) != 8'h00);
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      A_COUNT:   return m_count();
      A_COMPARE: return m_compare;
      A_STATUS:  return m_status();
      A_CAUSE:   return m_cause();
      A_EPC:     return m_epc;
      default:   return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs held across it.
  task automatic model_edge();
    logic        old_exl, hit, wst;
    if (rst) begin
      m_im = 0; m_ie = 0; m_exl = 0; m_bd = 0; m_ti = 0; m_exc = 0; m_ipsw = 0;
      m_epc = 0; m_compare = 0; m_cnt_base = 0; m_cnt_cycles = 0;
      m_hist.delete();
      return;
    end
    old_exl = m_exl;
    hit     = (m_count() == m_compare);
    wst     = mtc0_we && cp0_waddr == A_STATUS;
    if (exception) begin
      m_exl = 1; m_exc = ex_code;
      if (!old_exl) begin
        m_epc = ex_bd ? ex_pc - 4 : ex_pc;
        m_bd  = ex_bd;
      end
    end else if (eret_flush) begin
      m_exl = 0;
    end else if (wst) begin
      m_exl = mtc0_data[1];
    end
    if (wst) begin
      m_im = mtc0_data[15:8];
      m_ie = mtc0_data[0];
    end
    if (mtc0_we && cp0_waddr == A_CAUSE) m_ipsw = mtc0_data[9:8];
    if (mtc0_we && cp0_waddr == A_EPC && !(exception && !old_exl)) m_epc = mtc0_data;
    if (mtc0_we && cp0_waddr == A_COUNT) begin
      m_cnt_base = mtc0_data; m_cnt_cycles = 0;
    end else begin
      m_cnt_cycles++;
    end
    if (mtc0_we && cp0_waddr == A_COMPARE) begin
      m_compare = mtc0_data; m_ti = 0;
    end else if (hit) begin
      m_ti = 1;
    end
    m_hist.push_back(hw_int);
    if (m_hist.size() > SYNC) void'(m_hist.pop_front());
  endtask

  // One clock: check the read port before the edge (old value on RAW),
  // advance, then compare every output against the model.
  task automatic step();
    #1;
    check("rdata", cp0_rdata, m_read(cp0_raddr));
    @(posedge clk);
    #1;
    model_edge();
    check("status",    cp0_status, m_status());
    check("cause",     cp0_cause,  m_cause());
    check("epc",       cp0_epc,    m_epc);
    check("timer_int", 32'(timer_int), 32'(m_ti));
    check("int_req",   32'(int_req),   32'(m_int_req()));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    $display("mtc0 addr=%02h data=%08h", a, d);
    mtc0_we = 1; cp0_waddr = a; mtc0_data = d;
    step();
    mtc0_we = 0;
  endtask

  task automatic do_reset();
    $display("reset");
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic do_exc(input logic [31:0] pc, input logic bd, input logic [4:0] code);
    $display("exception pc=%08h bd=%0d code=%02h", pc, bd, code);
    exception = 1; ex_pc = pc; ex_bd = bd; ex_code = code;
    step();
    exception = 0;
  endtask

  initial begin
    rst = 1; mtc0_we = 0; cp0_waddr = '0; mtc0_data = '0; cp0_raddr = A_COUNT;
    exception = 0; ex_code = '0; ex_bd = 0; ex_pc = '0; eret_flush = 0; hw_int = '0;
    m_hist = {};

    // 1. Reset values and Status write masking
    do_reset();
    check("tp1_status", cp0_status, 32'h0040_0000);
    check("tp1_cause",  cp0_cause,  32'h0);
    check("tp1_epc",    cp0_epc,    32'h0);
    check("tp1_count",  cp0_rdata,  32'h0);
    check("tp1_intreq", 32'(int_req), 32'h0);
    cp0_raddr = A_STATUS;
    mtc0(A_STATUS, 32'h0000_FF03);
    check("tp1_status_wr", cp0_rdata, 32'h0040_FF03);

    // 2. Timer match, TI and acknowledge
    do_reset();
    mtc0(A_STATUS, 32'h0000_8001);
    mtc0(A_COMPARE, 32'd5);
    cp0_raddr = A_COUNT;
    mtc0(A_COUNT, 32'd3);
    idle(4);
    check("tp2_count5", cp0_rdata, 32'd5);
    step();
    check("tp2_ti",     32'(timer_int), 32'h1);
    check("tp2_cause",  cp0_cause, 32'h4000_8000);
    check("tp2_intreq", 32'(int_req), 32'h1);
    mtc0(A_COMPARE, 32'd5);
    check("tp2_ti_clr",  32'(timer_int), 32'h0);
    check("tp2_req_clr", 32'(int_req), 32'h0);

    // 3. Exception in delay slot, then nested exception
    do_reset();
    do_exc(32'hBFC0_0100, 1'b1, 5'h0c);
    check("tp3_epc",  cp0_epc, 32'hBFC0_00FC);
    check("tp3_bd",   32'(cp0_cause[31]), 32'h1);
    check("tp3_exc",  32'(cp0_cause[6:2]), 32'h0c);
    check("tp3_exl",  32'(cp0_status[1]), 32'h1);
    do_exc(32'h8000_0180, 1'b0, 5'h04);
    check("tp3_epc2", cp0_epc, 32'hBFC0_00FC);
    check("tp3_exc2", 32'(cp0_cause[6:2]), 32'h04);

    // 4. Event priority
    do_reset();
    eret_flush = 1;
    do_exc(32'h0000_1000, 1'b0, 5'h08);
    eret_flush = 0;
    check("tp4_exl_exc_eret", 32'(cp0_status[1]), 32'h1);
    eret_flush = 1; step(); eret_flush = 0;
    mtc0(A_STATUS, 32'h0000_0001);
    mtc0_we = 1; cp0_waddr = A_STATUS; mtc0_data = 32'h0;
    do_exc(32'h0000_2000, 1'b0, 5'h0a);
    mtc0_we = 0;
    check("tp4_exl", 32'(cp0_status[1]), 32'h1);
    check("tp4_ie",  32'(cp0_status[0]), 32'h0);

    // 5. Hardware interrupt synchroniser latency
    do_reset();
    mtc0(A_STATUS, 32'h0000_0401);
    hw_int = 6'b000001;
    step();
    check("tp5_ip_early", 32'(cp0_cause[10]), 32'h0);
    step();
    check("tp5_ip",     32'(cp0_cause[10]), 32'h1);
    check("tp5_intreq", 32'(int_req), 32'h1);
    mtc0(A_STATUS, 32'h0000_0403);
    check("tp5_exl_mask", 32'(int_req), 32'h0);
    hw_int = '0;
    step();
    check("tp5_ip_hold", 32'(cp0_cause[10]), 32'h1);
    step();
    check("tp5_ip_drop", 32'(cp0_cause[10]), 32'h0);

    // 6. Count wrap and load-beats-tick
    do_reset();
    cp0_raddr = A_COUNT;
    mtc0(A_COUNT, 32'hFFFF_FFFF);
    idle(2);
    check("tp6_wrap", cp0_rdata, 32'h0);
    mtc0(A_COUNT, 32'h0000_0100);
    step();                       // next edge is a tick
    mtc0(A_COUNT, 32'h0000_1234);
    check("tp6_load_tick", cp0_rdata, 32'h0000_1234);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      logic [7:0] addrs[6];
      logic [4:0] codes[7];
      addrs = '{A_COUNT, A_COMPARE, A_STATUS, A_CAUSE, A_EPC, 8'h00};
      codes = '{5'h00, 5'h04, 5'h05, 5'h08, 5'h09, 5'h0a, 5'h0c};
      rst        = ($urandom_range(0, 299) == 0);
      exception  = ($urandom_range(0, 19) == 0);
      eret_flush = ($urandom_range(0, 19) == 0);
      ex_code    = codes[$urandom_range(0, 6)];
      ex_bd      = $urandom_range(0, 1);
      ex_pc      = $urandom & 32'hFFFF_FFFC;
      mtc0_we    = ($urandom_range(0, 9) < 3);
      cp0_waddr  = addrs[$urandom_range(0, 5)];
      if (cp0_waddr == 8'h00) cp0_waddr = 8'($urandom);
      mtc0_data  = $urandom;
      if (cp0_waddr == A_COMPARE && $urandom_range(0, 1) == 1)
        mtc0_data = m_count() + $urandom_range(0, 6);
      if (cp0_waddr == A_COUNT && $urandom_range(0, 3) == 0)
        mtc0_data = 32'hFFFF_FFF0 | $urandom_range(0, 15);
      if (exception && cp0_waddr == A_EPC) mtc0_we = 0;
      if ($urandom_range(0, 7) == 0) hw_int = HW_N'($urandom);
      cp0_raddr  = addrs[$urandom_range(0, 5)];
      if (cp0_raddr == 8'h00) cp0_raddr = 8'($urandom);
      step();
    end
    rst = 0; mtc0_we = 0; exception = 0; eret_flush = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cp0_intr_ctrl.md
Name: cp0_intr_ctrl

Overview:
Parametrised CP0 interrupt/exception register block holding Status, Cause, EPC, Count and Compare, with a timer interrupt and synchronised hardware interrupt lines. It takes MTC0 writes, exception and ERET events from the writeback/commit stage. It drives a combinational MFC0 read port and the `int_req` line back to the exception-detect logic.

Parameters:
HW_INT_NUM, 6, number of external interrupt lines (1..6); line i maps to Cause.IP[2+i]
COUNT_DIV, 2, core cycles per Count increment (1..16)
SYNC_STAGES, 2, synchroniser depth for `hw_int` (>=1)
ADDR_W, 8, CP0 address width, {rd[4:0], sel[2:0]}

Ports:
clk  input  1  core clock
rst  input  1  synchronous reset, active-high
mtc0_we  input  1  MTC0 write strobe
cp0_waddr  input  ADDR_W  MTC0 target register
mtc0_data  input  32  MTC0 write data
cp0_raddr  input  ADDR_W  MFC0 source register
cp0_rdata  output  32  MFC0 read data (combinational)
exception  input  1  exception commit pulse
ex_code  input  5  ExcCode of committing exception
ex_bd  input  1  faulting instruction is in a delay slot
ex_pc  input  32  PC of faulting instruction
eret_flush  input  1  ERET commit pulse
hw_int  input  HW_INT_NUM  asynchronous level interrupt sources
cp0_status  output  32  current Status
cp0_cause  output  32  current Cause
cp0_epc  output  32  current EPC
timer_int  output  1  Cause.TI
int_req  output  1  interrupt pending and enabled

Behaviour:
- Addresses {rd,sel}: Count 9/0, Compare 11/0, Status 12/0, Cause 13/0, EPC 14/0. Any other address reads 0 and ignores writes.
- Status bits: BEV[22] is constant 1. IM[15:8], EXL[1] and IE[0] are writable. All other bits read 0.
  - Reset value 0x0040_0000; IM is reset too.
- Cause bits: BD[31], TI[30], IP[15:8], ExcCode[6:2]. Only IP[1:0] is MTC0-writable. All other bits read 0.
  - Reset value 0x0000_0000.
- IP[7:2]: IP[2+i] is the last stage of a SYNC_STAGES flop chain on hw_int[i]. IP bits for i >= HW_INT_NUM read 0.
  - IP[7] reads as (synced hw_int[5] if present) OR TI.
  - Latency: a hw_int edge is visible in IP SYNC_STAGES clock edges later.
- Event priority per cycle: rst > exception > eret_flush > mtc0.
- On exception:
  - EXL <= 1; ExcCode <= ex_code.
  - If EXL was 0: EPC <= ex_bd ? ex_pc-4 : ex_pc, and BD <= ex_bd.
  - If EXL was already 1: EPC and BD are unchanged.
- On eret_flush without exception: EXL <= 0.
- MTC0 to Status in the same cycle as an exception or ERET: the EXL write is dropped; the IM and IE writes still take effect.
- Count:
  - Divider phase counter runs 0..COUNT_DIV-1. Count increments when phase == COUNT_DIV-1.
  - Count wraps 0xFFFF_FFFF -> 0.
  - MTC0 Count loads the data and clears the phase. A load beats a same-cycle increment.
  - Reset: Count = 0, phase = 0.
- Compare/TI:
  - TI sets on the edge after registered Count == registered Compare, and stays set (sticky).
  - MTC0 Compare loads Compare and clears TI. The clear beats a same-cycle set.
  - Reset: Compare = 0, TI = 0. The match test is suppressed in the reset cycle.
- EPC is fully MTC0-writable; reset value 0.
- int_req = IE & ~EXL & |(IM & IP). It is combinational from registered state.
- cp0_rdata: a read in the same cycle as a write to that address returns the old value.
- Reset mid-operation: all registers, sync flops and the divider return to reset values on the next edge.

Decomposition:
- Package cp0_pkg holds:
  - CP0 address constants and bit-position constants (IE, EXL, IM, BEV, BD, TI, IP, ExcCode);
  - reset values for Status, Cause and EPC;
  - the ExcCode enum (Int=0x00, AdEL=0x04, AdES=0x05, Sys=0x08, Bp=0x09, RI=0x0a, Ov=0x0c).
- Sub-module cp0_count_timer contains the divider, Count, Compare and TI. Its ports are the write strobes and data, count, compare and ti.
- The top level instantiates it alongside the Status/Cause/EPC logic, the synchronisers and the read mux.

Test Plan:
1. Reset -> Status 0x0040_0000, Cause 0, EPC 0, Count 0, int_req 0. Write Status 0x0000_FF03 -> reads 0x0040_FF03.
2. COUNT_DIV=2: write Compare=5, then Count=3 -> Count=5 four cycles later and TI=1 one edge after that; Cause reads 0x4000_8000. With Status=0x0000_8001, int_req=1. Rewriting Compare=5 clears TI and int_req on the next edge.
3. Exception with ex_pc=0xBFC0_0100, ex_bd=1, ex_code=0x0c -> EPC=0xBFC0_00FC, BD=1, ExcCode=0x0c, EXL=1. A second exception with ex_pc=0x8000_0180, ex_code=0x04 -> EPC unchanged, ExcCode=0x04.
4. exception and eret_flush in the same cycle with EXL=0 -> EXL=1. MTC0 Status 0x0000_0000 in the same cycle as an exception -> EXL=1, IE=0.
5. SYNC_STAGES=2, Status=0x0000_0401: raise hw_int[0] -> IP[2]=1 and int_req=1 after exactly 2 edges. Set EXL -> int_req=0. Drop hw_int -> IP[2]=0 two edges later.
6. Write Count=0xFFFF_FFFF with COUNT_DIV=2 -> Count=0 two cycles later. A Count write coinciding with a tick loads the written value.
